s420_trojan_test_sequencer: RTL and testbench
=============================================

// Module: s420_trojan_test_sequencer
// PURPOSE
//   Stimulus/compare controller for the s420 benchmark pair: a suspect netlist (DUT) and a golden, trojan-free copy.
//   Drives identical pseudo-random C_0..C_16 / P_0 vectors to both from an LFSR and clocks them through a warm-up phase.
//   Then compares DUT Z against golden Z every cycle, recording mismatch count and first failing vector index.
//   Sits in the detection testbench/harness between the pattern source and the two benchmark instances.
// PARAMETERS
//   NUM_VECTORS    1024        compared vectors per run (1..2**CNT_W-1)
//   WARMUP_CYCLES  16          uncompared cycles after start; flushes X from benchmark flops (>=1)
//   CNT_W          16          width of index/mismatch counters
//   STOP_ON_FAIL   0           1: end run on first mismatch; 0: run all vectors
// PORTS
//   CK              in   1      clock; also clocks both benchmark instances
//   rst_n           in   1      synchronous active-low reset
//   start           in   1      run request, sampled on CK rising edge; ignored while busy
//   seed            in   24     LFSR seed, captured on accepted start; 0 is replaced by 24'h000001
//   c_vec           out  17     C_16..C_0 stimulus (bit i -> C_i), registered
//   p0              out  1      P_0 stimulus, registered
//   vec_valid       out  1      high in RUN: current c_vec/p0 is being compared
//   dut_z           in   1      Z from suspect instance (combinational response to current vector/state)
//   gold_z          in   1      Z from golden instance
//   busy            out  1      high in WARMUP or RUN
//   done            out  1      level, high in DONE until next accepted start or reset
//   fail            out  1      sticky: at least one mismatch this run
//   mismatch_cnt    out  CNT_W  mismatches this run, saturates at all-ones
//   first_fail_idx  out  CNT_W  vec_idx of first mismatch; valid only when fail=1, else 0
//   vec_idx         out  CNT_W  index of vector currently under compare
// BEHAVIOUR
//   Reset (rst_n=0 at edge, any state incl. mid-run): state=IDLE.
//     All outputs 0; LFSR=24'h000001.
//   LFSR: 24-bit Fibonacci, poly x^24+x^23+x^22+x^17+1; new bit0 = l[23]^l[22]^l[21]^l[16], shift left.
//     c_vec = lfsr[16:0], p0 = lfsr[23]. Advances one step every edge in WARMUP and RUN; frozen otherwise.
//   FSM: IDLE -> WARMUP on start. WARMUP -> RUN after WARMUP_CYCLES edges. RUN -> DONE after NUM_VECTORS compares,
//     or after the first mismatch if STOP_ON_FAIL=1. DONE -> WARMUP on start.
//   Accepted start (IDLE/DONE): lfsr<=seed (or 1); clears fail, mismatch_cnt, first_fail_idx, vec_idx; enters WARMUP.
//   start while busy: no effect. start and rst_n=0 same edge: reset wins.
//   Compare: each RUN edge samples dut_z^gold_z for the vector driven during the preceding cycle.
//     On mismatch: mismatch_cnt++ (saturating); on first mismatch also fail<=1, first_fail_idx<=vec_idx.
//     vec_idx++ each RUN edge except the last.
//   WARMUP compare results are discarded entirely.
//   Timing: start accepted at edge k -> vec_valid first high after edge k+WARMUP_CYCLES.
//     done high after edge k+WARMUP_CYCLES+NUM_VECTORS (STOP_ON_FAIL=0).
//   STOP_ON_FAIL=1, mismatch at vector n: DONE on that same edge; vec_idx stays n, vec_valid drops, LFSR frozen.
//   DONE/IDLE: c_vec/p0 hold last value.
//   X on dut_z/gold_z is not filtered; the bench guarantees WARMUP_CYCLES suffices.
// TESTING
//   T1 both inputs from one clean s420, seed 24'h000001, defaults -> done after 1040 cycles, fail=0, mismatch_cnt=0.
//   T2 dut_z=~gold_z from vec_idx 5 onward, STOP_ON_FAIL=0 -> mismatch_cnt=1019, first_fail_idx=5, fail=1.
//   T3 STOP_ON_FAIL=1, single mismatch at vector 100 -> done high next cycle, mismatch_cnt=1, first_fail_idx=100, vec_idx=100.
//   T4 seed=0 vs seed=1 -> identical c_vec/p0 sequences; first 8 LFSR states match the bench reference model.
//   T5 rst_n=0 at vector 300, then start same seed -> all outputs 0 after reset; rerun bit-identical to T1.
//   T6 CNT_W=4, NUM_VECTORS=15, all mismatching -> mismatch_cnt=15 (saturated).
//     Also: start pulsed while busy -> ignored, no counter clear.

Source files
------------

// File: rtl/s420_trojan_test_sequencer.sv
// Stimulus/compare sequencer for an s420 suspect/golden pair: drives identical LFSR
// vectors to both netlists, flushes them through a warm-up phase, then scores Z mismatches.
module s420_trojan_test_sequencer #(
  parameter int NUM_VECTORS   = 1024,
  parameter int WARMUP_CYCLES = 16,
  parameter int CNT_W         = 16,
  parameter bit STOP_ON_FAIL  = 1'b0
) (
  input  logic             CK,
  input  logic             rst_n,
  input  logic             start,
  input  logic [23:0]      seed,
  output logic [16:0]      c_vec,
  output logic             p0,
  output logic             vec_valid,
  input  logic             dut_z,
  input  logic             gold_z,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [CNT_W-1:0] vec_idx
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WARMUP = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int               WW        = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [WW-1:0]    WARM_LAST = WW'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] VEC_LAST  = CNT_W'(NUM_VECTORS - 1);

  logic [1:0]       r_state;
  logic [23:0]      r_lfsr;
  logic [16:0]      r_c_vec;
  logic             r_p0;
  logic [WW-1:0]    r_warm_cnt;
  logic [CNT_W-1:0] r_vec_idx;
  logic [CNT_W-1:0] r_mismatch_cnt;
  logic [CNT_W-1:0] r_first_fail_idx;
  logic             r_fail;

  logic [23:0] w_lfsr_step;
  logic [23:0] w_seed_eff;
  logic        w_mismatch;
  logic        w_last_vec;

  assign w_lfsr_step = {r_lfsr[22:0], r_lfsr[23] ^ r_lfsr[22] ^ r_lfsr[21] ^ r_lfsr[16]};
  assign w_seed_eff  = (seed == 24'd0) ? 24'h000001 : seed;
  assign w_mismatch  = dut_z ^ gold_z;
  assign w_last_vec  = (r_vec_idx == VEC_LAST);

  // c_vec/p0 are separate copies of the LFSR taps so they can read 0 after reset
  // while the LFSR itself sits at its non-zero reset value.
  always_ff @(posedge CK) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_lfsr           <= 24'h000001;
      r_c_vec          <= '0;
      r_p0             <= 1'b0;
      r_warm_cnt       <= '0;
      r_vec_idx        <= '0;
      r_mismatch_cnt   <= '0;
      r_first_fail_idx <= '0;
      r_fail           <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state          <= S_WARMUP;
            r_lfsr           <= w_seed_eff;
            r_c_vec          <= w_seed_eff[16:0];
            r_p0             <= w_seed_eff[23];
            r_warm_cnt       <= '0;
            r_vec_idx        <= '0;
            r_mismatch_cnt   <= '0;
            r_first_fail_idx <= '0;
            r_fail           <= 1'b0;
          end
        end
        S_WARMUP: begin
          r_lfsr  <= w_lfsr_step;
          r_c_vec <= w_lfsr_step[16:0];
          r_p0    <= w_lfsr_step[23];
          if (r_warm_cnt == WARM_LAST) begin
            r_state    <= S_RUN;
            r_warm_cnt <= '0;
          end else begin
            r_warm_cnt <= r_warm_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (w_mismatch) begin
            if (r_mismatch_cnt != '1) begin
              r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
            end
            if (!r_fail) begin
              r_fail           <= 1'b1;
              r_first_fail_idx <= r_vec_idx;
            end
          end
          // An early stop leaves the failing vector on the outputs for inspection.
          if (STOP_ON_FAIL && w_mismatch) begin
            r_state <= S_DONE;
          end else begin
            r_lfsr  <= w_lfsr_step;
            r_c_vec <= w_lfsr_step[16:0];
            r_p0    <= w_lfsr_step[23];
            if (w_last_vec) begin
              r_state <= S_DONE;
            end else begin
              r_vec_idx <= r_vec_idx + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign c_vec          = r_c_vec;
  assign p0             = r_p0;
  assign vec_valid      = (r_state == S_RUN);
  assign busy           = (r_state == S_WARMUP) || (r_state == S_RUN);
  assign done           = (r_state == S_DONE);
  assign fail           = r_fail;
  assign mismatch_cnt   = r_mismatch_cnt;
  assign first_fail_idx = r_first_fail_idx;
  assign vec_idx        = r_vec_idx;

endmodule

// File: tb/tb_s420_trojan_test_sequencer.sv
// Self-checking bench for s420_trojan_test_sequencer: default, stop-on-fail and
// narrow-counter instances share one clock; an LFSR model feeds a vector scoreboard.
module tb_s420_trojan_test_sequencer;

  localparam int W = 16;
  localparam int N = 1024;

  logic CK = 1'b0;
  logic rst_n = 1'b0;

  logic        start_d = 1'b0, start_s = 1'b0, start_m = 1'b0;
  logic [23:0] seed_d = '0, seed_s = '0, seed_m = '0;

  logic [16:0] c_vec_d, c_vec_s, c_vec_m;
  logic        p0_d, p0_s, p0_m;
  logic        vec_valid_d, vec_valid_s, vec_valid_m;
  logic        busy_d, busy_s, busy_m;
  logic        done_d, done_s, done_m;
  logic        fail_d, fail_s, fail_m;
  logic [15:0] mis_d, mis_s, ffi_d, ffi_s, idx_d, idx_s;
  logic [3:0]  mis_m, ffi_m, idx_m;
  logic        gz_d, dz_d, gz_s, dz_s, gz_m, dz_m;

  int inj_from = 0;
  int inj_to   = -1;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];

  // Stand-in for an s420 Z: any deterministic function of the applied vector works here.
  assign gz_d = ^c_vec_d ^ p0_d;
  assign dz_d = gz_d ^ (vec_valid_d && (int'(idx_d) >= inj_from) && (int'(idx_d) <= inj_to));
  assign gz_s = ^c_vec_s ^ p0_s;
  assign dz_s = gz_s ^ (vec_valid_s && (idx_s == 16'd100));
  assign gz_m = ^c_vec_m ^ p0_m;
  assign dz_m = ~gz_m;

  always #5 CK = ~CK;

  s420_trojan_test_sequencer u_dut (
    .CK(CK), .rst_n(rst_n), .start(start_d), .seed(seed_d), .c_vec(c_vec_d), .p0(p0_d),
    .vec_valid(vec_valid_d), .dut_z(dz_d), .gold_z(gz_d), .busy(busy_d), .done(done_d),
    .fail(fail_d), .mismatch_cnt(mis_d), .first_fail_idx(ffi_d), .vec_idx(idx_d)
  );

  s420_trojan_test_sequencer #(.STOP_ON_FAIL(1'b1)) u_stop (
    .CK(CK), .rst_n(rst_n), .start(start_s), .seed(seed_s), .c_vec(c_vec_s), .p0(p0_s),
    .vec_valid(vec_valid_s), .dut_z(dz_s), .gold_z(gz_s), .busy(busy_s), .done(done_s),
    .fail(fail_s), .mismatch_cnt(mis_s), .first_fail_idx(ffi_s), .vec_idx(idx_s)
  );

  s420_trojan_test_sequencer #(.CNT_W(4), .NUM_VECTORS(15)) u_small (
    .CK(CK), .rst_n(rst_n), .start(start_m), .seed(seed_m), .c_vec(c_vec_m), .p0(p0_m),
    .vec_valid(vec_valid_m), .dut_z(dz_m), .gold_z(gz_m), .busy(busy_m), .done(done_m),
    .fail(fail_m), .mismatch_cnt(mis_m), .first_fail_idx(ffi_m), .vec_idx(idx_m)
  );

  function automatic logic [23:0] lfsr_step(input logic [23:0] l);
    return {l[22:0], l[23] ^ l[22] ^ l[21] ^ l[16]};
  endfunction

  task automatic push_expected(input logic [23:0] s, input int n);
    logic [23:0] l;
    l = s;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({l[23], l[16:0]});
      l = lfsr_step(l);
    end
  endtask

  // Every busy cycle of the default instance must present the next model vector.
  always @(negedge CK) begin
    if (busy_d) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL vec_scoreboard got %h exp <queue empty>", {p0_d, c_vec_d});
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        if ({p0_d, c_vec_d} !== e) begin
          errors++;
          $display("[TB] FAIL vec_scoreboard got %h exp %h", {p0_d, c_vec_d}, e);
        end
      end
    end
  end

  task automatic start_default(input logic [23:0] s);
    @(posedge CK); #1;
    seed_d = s; start_d = 1'b1;
    @(posedge CK); #1;
    start_d = 1'b0;
  endtask

  task automatic check_full_run(input string name, input int exp_mis, input int exp_ffi, input bit exp_fail);
    int cyc;
    cyc = 0;
    while (!done_d && cyc < 3000) begin
      @(posedge CK); #1; cyc++;
    end
    checks++;
    if (cyc !== W + N) begin errors++; $display("[TB] FAIL %s_done_cycles got %0d exp %0d", name, cyc, W + N); end
    checks++;
    if (mis_d !== 16'(exp_mis)) begin errors++; $display("[TB] FAIL %s_mismatch_cnt got %0d exp %0d", name, mis_d, exp_mis); end
    checks++;
    if (ffi_d !== 16'(exp_ffi)) begin errors++; $display("[TB] FAIL %s_first_fail_idx got %0d exp %0d", name, ffi_d, exp_ffi); end
    checks++;
    if (fail_d !== exp_fail) begin errors++; $display("[TB] FAIL %s_fail got %b exp %b", name, fail_d, exp_fail); end
    checks++;
    if ({busy_d, vec_valid_d, idx_d} !== {1'b0, 1'b0, 16'(N - 1)}) begin
      errors++; $display("[TB] FAIL %s_end_state got busy=%b valid=%b idx=%0d exp 0 0 %0d", name, busy_d, vec_valid_d, idx_d, N - 1);
    end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("[TB] FAIL %s_queue_left got %0d exp 0", name, exp_q.size()); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge CK);
    #1;
    checks++;
    if ({c_vec_d, p0_d, vec_valid_d, busy_d, done_d, fail_d, mis_d, ffi_d, idx_d} !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs got c=%h p0=%b busy=%b done=%b idx=%0d exp all 0", c_vec_d, p0_d, busy_d, done_d, idx_d);
    end
    checks++;
    if ({busy_s, done_s, busy_m, done_m} !== 4'b0) begin
      errors++; $display("[TB] FAIL reset_other got %b exp 0000", {busy_s, done_s, busy_m, done_m});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_clean_run();
    inj_from = 0; inj_to = -1;
    push_expected(24'h000001, W + N);
    start_default(24'h000001);
    check_full_run("t1", 0, 0, 1'b0);
  endtask

  task automatic test_persistent_mismatch();
    int cyc;
    inj_from = 5; inj_to = 1 << 20;
    push_expected(24'h3C5A96, W + N);
    start_default(24'h3C5A96);
    cyc = 0;
    while (idx_d != 16'd50 && cyc < 3000) begin
      @(posedge CK); #1; cyc++;
    end
    seed_d = 24'hABCDEF; start_d = 1'b1;
    @(posedge CK); #1;
    start_d = 1'b0;
    checks++;
    if ({busy_d, idx_d, mis_d} !== {1'b1, 16'd51, 16'd46}) begin
      errors++; $display("[TB] FAIL busy_start_ignored got busy=%b idx=%0d mis=%0d exp 1 51 46", busy_d, idx_d, mis_d);
    end
    // The remaining run takes fewer cycles than a full one, so finish it with a plain wait.
    cyc = 0;
    while (!done_d && cyc < 3000) begin
      @(posedge CK); #1; cyc++;
    end
    checks++;
    if ({fail_d, mis_d, ffi_d} !== {1'b1, 16'd1019, 16'd5}) begin
      errors++; $display("[TB] FAIL t2_results got fail=%b mis=%0d ffi=%0d exp 1 1019 5", fail_d, mis_d, ffi_d);
    end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("[TB] FAIL t2_queue_left got %0d exp 0", exp_q.size()); end
    inj_from = 0; inj_to = -1;
  endtask

  task automatic test_stop_on_fail();
    int cyc;
    logic [23:0] l;
    @(posedge CK); #1;
    seed_s = 24'h0F1E2D; start_s = 1'b1;
    @(posedge CK); #1;
    start_s = 1'b0;
    cyc = 0;
    while (!done_s && cyc < 3000) begin
      @(posedge CK); #1; cyc++;
    end
    checks++;
    if (cyc !== W + 101) begin errors++; $display("[TB] FAIL t3_done_cycles got %0d exp %0d", cyc, W + 101); end
    checks++;
    if ({fail_s, mis_s, ffi_s, idx_s} !== {1'b1, 16'd1, 16'd100, 16'd100}) begin
      errors++; $display("[TB] FAIL t3_results got fail=%b mis=%0d ffi=%0d idx=%0d exp 1 1 100 100", fail_s, mis_s, ffi_s, idx_s);
    end
    l = 24'h0F1E2D;
    for (int i = 0; i < W + 100; i++) l = lfsr_step(l);
    repeat (2) @(posedge CK);
    #1;
    checks++;
    if ({vec_valid_s, busy_s, p0_s, c_vec_s} !== {1'b0, 1'b0, l[23], l[16:0]}) begin
      errors++; $display("[TB] FAIL t3_frozen got valid=%b busy=%b vec=%h exp 0 0 %h", vec_valid_s, busy_s, {p0_s, c_vec_s}, {l[23], l[16:0]});
    end
  endtask

  task automatic test_zero_seed();
    push_expected(24'h000001, 8);
    start_default(24'h000000);
    checks++;
    if ({p0_d, c_vec_d} !== 18'h00001) begin
      errors++; $display("[TB] FAIL t4_seed_replaced got %h exp 00001", {p0_d, c_vec_d});
    end
    repeat (7) @(posedge CK);
    @(negedge CK); #1;
    rst_n = 1'b0;
    @(posedge CK); #1;
    rst_n = 1'b1;
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("[TB] FAIL t4_queue_left got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    push_expected(24'h000001, W + N);
    start_default(24'h000001);
    cyc = 0;
    while (idx_d != 16'd300 && cyc < 3000) begin
      @(posedge CK); #1; cyc++;
    end
    rst_n = 1'b0; seed_d = 24'h000001; start_d = 1'b1;
    @(posedge CK); #1;
    rst_n = 1'b1; start_d = 1'b0;
    checks++;
    if ({c_vec_d, p0_d, vec_valid_d, busy_d, done_d, fail_d, mis_d, ffi_d, idx_d} !== '0) begin
      errors++; $display("[TB] FAIL t5_reset_outputs got c=%h busy=%b done=%b idx=%0d exp all 0", c_vec_d, busy_d, done_d, idx_d);
    end
    exp_q.delete();
    push_expected(24'h000001, W + N);
    start_default(24'h000001);
    check_full_run("t5", 0, 0, 1'b0);
  endtask

  task automatic test_saturation();
    int cyc;
    @(posedge CK); #1;
    seed_m = 24'h5A5A5A; start_m = 1'b1;
    @(posedge CK); #1;
    start_m = 1'b0;
    cyc = 0;
    while (!done_m && cyc < 200) begin
      @(posedge CK); #1; cyc++;
    end
    checks++;
    if (cyc !== W + 15) begin errors++; $display("[TB] FAIL t6_done_cycles got %0d exp %0d", cyc, W + 15); end
    checks++;
    if ({fail_m, mis_m, ffi_m, idx_m} !== {1'b1, 4'hF, 4'h0, 4'hE}) begin
      errors++; $display("[TB] FAIL t6_results got fail=%b mis=%0d ffi=%0d idx=%0d exp 1 15 0 14", fail_m, mis_m, ffi_m, idx_m);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout exp completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_clean_run();
    test_persistent_mismatch();
    test_stop_on_fail();
    test_zero_seed();
    test_reset_midrun();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
